// File: rtl/serial_adder.sv
// Bit-serial adder: operands are shifted LSB-first through a single full-adder
// cell, one bit pair per clock. The handshake on the input side captures a, b
// and cin; the handshake on the output side delivers the WIDTH-bit sum and the
// carry-out.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic              carry;
    logic              cout_reg;
    logic [CW-1:0]     count;
    logic              fa_sum;
    logic              fa_cout;
    logic [WIDTH:0]    sum_shift;

    full_adder u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Insert the new sum bit at the MSB while the oldest bits move toward the LSB.
    always_comb begin
        sum_shift = {fa_sum, sum_reg};
    end

    // Handshake/sequencing FSM with the shift datapath and registered status outputs.
    // cout has its own register so it keeps the previous result after a new
    // accept reloads the working carry with cin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry     <= 1'b0;
            cout_reg  <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= cin;
                        count    <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    sum_reg <= sum_shift[WIDTH:1];
                    carry   <= fa_cout;
                    if (count == CW'(WIDTH - 1)) begin
                        cout_reg  <= fa_cout;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
